// File: rtl/table_loader_if.sv
// Bundles the load-request, stream, memory and status signals of table_loader.
// The master side drives requests, stream words and read data; the slave side is the loader.
interface table_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CSUM_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  done;
    logic                  verify_ok;
    logic [CSUM_WIDTH-1:0] checksum;
    logic                  err;

    modport master (
        output start, base_addr, length, s_valid, s_data, rdata,
        input  s_ready, we, waddr, wdata, re, raddr, busy, done, verify_ok, checksum, err
    );

    modport slave (
        input  start, base_addr, length, s_valid, s_data, rdata,
        output s_ready, we, waddr, wdata, re, raddr, busy, done, verify_ok, checksum, err
    );
endinterface

// File: rtl/table_loader.sv
// Streams a block of words into a table memory while summing them, then reads the
// block back and compares the read-back sum against the load checksum.
module table_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CSUM_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    table_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY, DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    state_t state, state_nxt;

    logic [ADDR_WIDTH:0]   len, cnt;
    logic [ADDR_WIDTH-1:0] base, wptr;
    logic [CSUM_WIDTH-1:0] csum, vsum, vsum_fin;

    logic                  we_p1, re_p0, rd_vld_p1, done_q, err_q, ok_q;
    logic [ADDR_WIDTH-1:0] waddr_p1, raddr_p0;
    logic [DATA_WIDTH-1:0] wdata_p1;

    logic start_ok, start_bad, accept, last_cnt;
    logic s_ready, busy, re_nxt, done_nxt;

    function automatic logic [CSUM_WIDTH-1:0] csum_add(input logic [CSUM_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] word);
        return acc + CSUM_WIDTH'(word);
    endfunction

    assign start_ok  = (state == IDLE) && bus.start && (bus.length != '0);
    assign start_bad = (state == IDLE) && bus.start && (bus.length == '0);
    assign accept    = bus.s_valid && s_ready;
    // cnt counts accepted words in LOAD and issued reads in VERIFY
    assign last_cnt  = (cnt == len - CNT_ONE);
    assign vsum_fin  = rd_vld_p1 ? csum_add(vsum, bus.rdata) : vsum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    if (accept && last_cnt) state_nxt = FLUSH;
            FLUSH:   state_nxt = VERIFY;
            VERIFY:  if (last_cnt) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        busy     = 1'b0;
        re_nxt   = 1'b0;
        done_nxt = 1'b0;
        case (state)
            LOAD:    begin s_ready = 1'b1; busy = 1'b1; end
            FLUSH:   begin busy = 1'b1; re_nxt = 1'b1; end
            VERIFY:  begin busy = 1'b1; re_nxt = !last_cnt; end
            DRAIN:   done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            cnt       <= '0;
            base      <= '0;
            wptr      <= '0;
            csum      <= '0;
            vsum      <= '0;
            we_p1     <= 1'b0;
            waddr_p1  <= '0;
            wdata_p1  <= '0;
            re_p0     <= 1'b0;
            raddr_p0  <= '0;
            rd_vld_p1 <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            // p0 -> p1: write port trails the accepted word by one cycle
            we_p1     <= accept;
            re_p0     <= re_nxt;
            // p1: memory returns data one cycle after each read request
            rd_vld_p1 <= re_p0;
            done_q    <= done_nxt;
            err_q     <= start_bad;
            if (start_ok) begin
                len  <= bus.length;
                base <= bus.base_addr;
                wptr <= bus.base_addr;
                cnt  <= '0;
                csum <= '0;
                vsum <= '0;
                ok_q <= 1'b0;
            end
            if (accept) begin
                waddr_p1 <= wptr;
                wdata_p1 <= bus.s_data;
                wptr     <= wptr + PTR_ONE;
                csum     <= csum_add(csum, bus.s_data);
                cnt      <= last_cnt ? '0 : cnt + CNT_ONE;
            end
            if (state == FLUSH) raddr_p0 <= base;
            if (state == VERIFY) begin
                cnt <= cnt + CNT_ONE;
                if (!last_cnt) raddr_p0 <= raddr_p0 + PTR_ONE;
            end
            if (rd_vld_p1) vsum <= vsum_fin;
            if (state == DRAIN) ok_q <= (vsum_fin == csum);
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.busy      = busy;
    assign bus.we        = we_p1;
    assign bus.waddr     = waddr_p1;
    assign bus.wdata     = wdata_p1;
    assign bus.re        = re_p0;
    assign bus.raddr     = raddr_p0;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.verify_ok = ok_q;
    assign bus.checksum  = csum;
endmodule

// File: tb/tb_table_loader.sv
// Random-stimulus bench for table_loader with a behavioural memory and an
// expected-result model built from the job description (addresses, sum, latency).
module tb_table_loader;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    table_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CSUM_WIDTH(CW)) bus ();

    table_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CSUM_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural table memory with optional single-address corruption on write
    logic [DW-1:0] mem [0:255];
    bit            corrupt_on = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    always @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= (corrupt_on && bus.waddr == corrupt_addr) ? (bus.wdata ^ 8'h5A) : bus.wdata;
        if (bus.re) bus.rdata <= mem[bus.raddr];
    end

    // Observation queues, filled away from the active edge
    logic [15:0]   wq [$];
    logic [AW-1:0] rq [$];
    int            done_q [$];
    int            err_q [$];
    int            busy_q [$];
    always @(negedge clk) begin
        if (bus.we)   wq.push_back({bus.waddr, bus.wdata});
        if (bus.re)   rq.push_back(bus.raddr);
        if (bus.done) done_q.push_back(cyc);
        if (bus.err)  err_q.push_back(cyc);
        if (bus.busy) busy_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wq.delete();
        rq.delete();
        done_q.delete();
        err_q.delete();
        busy_q.delete();
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int len, input bit fixed,
                           input bit gaps, input bit mid_start, input bit corrupt,
                           input logic [AW-1:0] caddr);
        logic [DW-1:0] words [$];
        logic [15:0]   exp_w;
        logic [AW-1:0] a;
        int            sum, idx, n, start_cyc, exp_ok;
        bit            hit;
        words.delete();
        sum = 0;
        hit = 1'b0;
        for (int i = 0; i < len; i++) begin
            words.push_back(fixed ? DW'(i + 1) : DW'($urandom));
            sum = (sum + int'(words[i])) % 65536;
            a = base + AW'(i);
            if (a == caddr) hit = 1'b1;
        end
        exp_ok = (corrupt && hit) ? 0 : 1;
        corrupt_on   = corrupt;
        corrupt_addr = caddr;

        @(negedge clk);
        clear_obs();
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = (AW+1)'(len);
        start_cyc     = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.length    = (AW+1)'(5);
        idx = 0;
        n   = 0;
        while (done_q.size() == 0 && n < 2000) begin
            bus.s_valid = (idx < len) && (!gaps || (n % 2 == 0));
            bus.s_data  = (idx < len) ? words[idx] : DW'($urandom);
            bus.start   = mid_start && (n == 2);
            #4;
            if (bus.s_valid && bus.s_ready) idx++;
            @(negedge clk);
            n++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        repeat (3) @(negedge clk);

        check("done_count", done_q.size(), 1);
        if (!gaps) check("done_latency", done_q[0] - start_cyc, 2 * len + 3);
        check("wr_count", wq.size(), len);
        for (int i = 0; i < len && i < wq.size(); i++) begin
            exp_w = {base + AW'(i), words[i]};
            check($sformatf("wr%0d", i), wq[i], exp_w);
        end
        check("rd_count", rq.size(), len);
        for (int i = 0; i < len && i < rq.size(); i++) begin
            a = base + AW'(i);
            check($sformatf("rd%0d", i), rq[i], a);
        end
        check("checksum", bus.checksum, sum);
        check("verify_ok", bus.verify_ok, exp_ok);
        check("no_err", err_q.size(), 0);
        check("idle_busy", bus.busy, 0);
        corrupt_on = 1'b0;
    endtask

    task automatic zero_length();
        logic [CW-1:0] ck_before;
        logic          ok_before;
        @(negedge clk);
        clear_obs();
        ck_before     = bus.checksum;
        ok_before     = bus.verify_ok;
        bus.start     = 1'b1;
        bus.base_addr = AW'($urandom);
        bus.length    = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("len0_err", err_q.size(), 1);
        check("len0_busy", busy_q.size(), 0);
        check("len0_we", wq.size(), 0);
        check("len0_checksum", bus.checksum, ck_before);
        check("len0_verify_ok", bus.verify_ok, ok_before);
    endtask

    task automatic abort_in_verify();
        int n;
        @(negedge clk);
        clear_obs();
        bus.start     = 1'b1;
        bus.base_addr = AW'($urandom);
        bus.length    = (AW+1)'(6);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.s_valid = 1'b1;
        n = 0;
        while (!bus.re && n < 100) begin
            bus.s_data = DW'($urandom);
            @(negedge clk);
            n++;
        end
        check("reach_verify", bus.re, 1);
        bus.s_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("abort_ctrl", {bus.s_ready, bus.we, bus.re, bus.busy, bus.done, bus.verify_ok, bus.err}, 0);
        check("abort_waddr", bus.waddr, 0);
        check("abort_wdata", bus.wdata, 0);
        check("abort_raddr", bus.raddr, 0);
        check("abort_checksum", bus.checksum, 0);
        @(negedge clk);
        clear_obs();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_we", wq.size(), 0);
        check("abort_no_re", rq.size(), 0);
        check("abort_no_done", done_q.size(), 0);
        check("abort_idle", busy_q.size(), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] b;
        int            l;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.s_ready, bus.we, bus.re, bus.busy, bus.done, bus.verify_ok, bus.err}, 0);
        check("reset_checksum", bus.checksum, 0);
        check("reset_addr", {bus.waddr, bus.raddr}, 0);
        rst = 1'b0;

        run_job(8'h10, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("basic_checksum", bus.checksum, 16'h000A);
        run_job(8'h10, 4, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        check("corrupt_checksum", bus.checksum, 16'h000A);
        run_job(8'hFE, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        zero_length();
        run_job(8'h40, 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        abort_in_verify();
        run_job(8'h80, 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        for (int j = 0; j < 6; j++) begin
            b = AW'($urandom);
            l = $urandom_range(1, 24);
            run_job(b, l, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                    b + AW'($urandom_range(0, l - 1)));
        end
        run_job(AW'($urandom), 256, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/table_loader.md
TABLE_LOADER -- requirements
Module: table_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 8, memory address width; table depth is 2**ADDR_WIDTH.
REQ-003 Parameter CSUM_WIDTH, default 16, checksum width, SHALL be >= DATA_WIDTH.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle load request, sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first table address, captured at accepted start.
REQ-008 length  input  ADDR_WIDTH+1  word count 1..2**ADDR_WIDTH, captured at accepted start.
REQ-009 s_valid  input  1  stream word valid.
REQ-010 s_data  input  DATA_WIDTH  stream word.
REQ-011 s_ready  output  1  stream word accepted when s_valid && s_ready.
REQ-012 we / waddr / wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  registered memory write port.
REQ-013 re / raddr  output  1 / ADDR_WIDTH  registered memory read request.
REQ-014 rdata  input  DATA_WIDTH  memory read data, valid exactly one cycle after re.
REQ-015 busy  output  1  high in LOAD, FLUSH and VERIFY.
REQ-016 done  output  1  one-cycle pulse at job end.
REQ-017 verify_ok  output  1  result of last job, held until next accepted start.
REQ-018 checksum  output  CSUM_WIDTH  load-phase checksum of last job, held.
REQ-019 err  output  1  one-cycle pulse on rejected start.

Function
REQ-020 States SHALL be IDLE, LOAD, FLUSH, VERIFY, DRAIN.
REQ-021 IDLE: start && length!=0 -> LOAD; capture base_addr and length, clear checksum and verify_ok.
REQ-022 IDLE: start && length==0 -> err=1 for one cycle, remain IDLE, all other outputs unchanged.
REQ-023 start outside IDLE SHALL be ignored with no err.
REQ-024 s_ready SHALL equal 1 exactly when state is LOAD.
REQ-025 Each accepted word: next cycle we=1, waddr=current pointer, wdata=word; pointer increments modulo 2**ADDR_WIDTH (wraps past all-ones to 0).
REQ-026 checksum SHALL accumulate the zero-extended accepted word, modulo 2**CSUM_WIDTH.
REQ-027 When accept count reaches length, LOAD -> FLUSH; FLUSH lasts one cycle, in which the final we pulse occurs; no reads are issued in FLUSH.
REQ-028 s_valid low in LOAD SHALL stall without timeout; we=0 on stall cycles.
REQ-029 VERIFY issues re=1 for length consecutive cycles, raddr from base_addr with the same wrap rule, then -> DRAIN.
REQ-030 rdata sampled one cycle after each re SHALL be summed into a verify sum of identical width and rule.
REQ-031 DRAIN lasts one cycle to capture the final rdata; on the following cycle done=1, verify_ok = (verify sum == checksum), state -> IDLE.
REQ-032 Throughput SHALL be one word per cycle in LOAD and one read per cycle in VERIFY.
REQ-033 A job SHALL end with done exactly length+length+3 cycles after start acceptance when s_valid is held high.
REQ-034 length == 2**ADDR_WIDTH SHALL write every address once, ending at base_addr-1 modulo depth.

Reset
REQ-035 rst high SHALL asynchronously force IDLE and drive s_ready, we, waddr, wdata, re, raddr, busy, done, verify_ok, checksum, err to 0.
REQ-036 rst mid-job SHALL abandon the job; no further we or re until a new accepted start after rst deasserts.

Verification
REQ-037 base_addr=0x10, length=4, words 0x01,0x02,0x03,0x04 continuous -> writes at 0x10..0x13, checksum=0x000A, done at cycle 11 after start, verify_ok=1 with a correct memory model.
REQ-038 base_addr=0xFE, length=3 -> waddr sequence 0xFE, 0xFF, 0x00; raddr sequence identical.
REQ-039 start with length=0 -> single err pulse, busy stays 0, no we.
REQ-040 Memory model corrupts address 0x11 after the write in scenario REQ-037 -> done with verify_ok=0, checksum still 0x000A.
REQ-041 s_valid toggled every other cycle plus start pulsed during LOAD -> correct write sequence, no err, second start ignored.
REQ-042 rst asserted during VERIFY -> all outputs 0 immediately; a subsequent job completes normally.
